ins_fetch: RTL

//  Producer end of the fetch->decode interface: owns the PC, fetches 32-bit words from the icache/memory

---
 rtl/ins_fetch_pkg.sv | 39 +++
 rtl/ins_fetch_queue.sv | 106 ++++++++++
 rtl/ins_fetch.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ins_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ins_fetch_pkg
//   Shared definitions for the instruction fetch slice: PC width, the JAL
//   opcode, the fetch FSM state type, the queue entry layout and the JAL
//   immediate decoder used when JAL_FOLLOW_EN is defined.
//   No ports; imported by ins_fetch and ins_fetch_queue.
// ----------------------------------------------------------------------------
package ins_fetch_pkg;

  // Width of every program counter carried through the fetch path.
  localparam int PC_WIDTH = 32;

  // RISC-V JAL major opcode (instruction bits [6:0]).
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  // Fetch FSM states.
  //   FS_IDLE : no request outstanding, may issue one
  //   FS_WAIT : request outstanding, response will be pushed
  //   FS_DROP : request outstanding, response will be thrown away
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  // One buffered fetch: the word, where it came from, and where fetch
  // expects to go next.
  typedef struct packed {
    logic [31:0]         ins;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pred_pc;
  } fetch_entry_t;

  // Sign-extended J-type immediate; bit 0 is always zero.
  function automatic logic [PC_WIDTH-1:0] jal_offset(input logic [31:0] word);
    return {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ins_fetch_queue.sv
// ----------------------------------------------------------------------------
// ins_fetch_queue
//   Circular FIFO of fetched instructions {ins, pc, pred_pc}. Depth is
//   2**DEPTH_LOG and every slot is usable. Head fields come straight from the
//   slot registers.
//
// Parameters
//   DEPTH_LOG        log2 of the number of slots
// Ports
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   push_i           write push_* into the tail slot
//   pop_i            drop the head slot (ignored while empty)
//   clear_i          empty the queue; overrides push and pop
//   push_ins_i       instruction word to push
//   push_pc_i        PC of the pushed word
//   push_pred_pc_i   predicted next PC of the pushed word
//   full_o           every slot holds an entry
//   empty_o          no entries
//   head_ins_o       instruction at the head
//   head_pc_o        PC at the head
//   head_pred_pc_o   predicted next PC at the head
// ----------------------------------------------------------------------------
module ins_fetch_queue
  import ins_fetch_pkg::*;
#(
  parameter int DEPTH_LOG = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  logic [31:0] push_ins_i,
  input  logic [31:0] push_pc_i,
  input  logic [31:0] push_pred_pc_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [31:0] head_ins_o,
  output logic [31:0] head_pc_o,
  output logic [31:0] head_pred_pc_o
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);

  fetch_entry_t           slots_q [DEPTH];
  fetch_entry_t           push_entry;
  fetch_entry_t           head_entry;
  logic [DEPTH_LOG-1:0]   head_q;
  logic [DEPTH_LOG-1:0]   tail_q;
  logic [DEPTH_LOG:0]     count_q;
  logic                   do_push;
  logic                   do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);

  // A push into a full queue is only accepted when the head leaves in the
  // same cycle, so no live entry is ever overwritten.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign push_entry.ins     = push_ins_i;
  assign push_entry.pc      = push_pc_i;
  assign push_entry.pred_pc = push_pred_pc_i;

  assign head_entry     = slots_q[head_q];
  assign head_ins_o     = head_entry.ins;
  assign head_pc_o      = head_entry.pc;
  assign head_pred_pc_o = head_entry.pred_pc;

  // Pointer and occupancy bookkeeping. Pointers are exactly DEPTH_LOG bits
  // wide so incrementing past the last slot wraps to slot 0 by itself.
  // Slots are reset so the head reads as zero out of reset; a clear only
  // rewinds the pointers and leaves stale slot contents behind, which is
  // harmless because the queue reports empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots_q[i] <= '0;
      end
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        slots_q[tail_q] <= push_entry;
        tail_q          <= tail_q + 1'b1;
      end
      if (do_pop) begin
        head_q <= head_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ins_fetch.sv
// ----------------------------------------------------------------------------
// ins_fetch
//   Producer end of the fetch->decode interface. Owns the PC, fetches one
//   32-bit word at a time from the icache/memory controller over a req/done
//   handshake and buffers each word with its PC and predicted next PC in
//   ins_fetch_queue. A flush redirects the PC and discards everything that is
//   buffered or still in flight.
//
// Configuration macro
//   JAL_FOLLOW_EN    when defined, a fetched JAL redirects fetch to its target
//                    and the target becomes the entry's predicted PC; when
//                    undefined every word predicts pc+4.
//
// Parameters
//   QUEUE_DEPTH_LOG  log2 of queue depth
//   RESET_PC         PC after reset
// Ports
//   clk_in           clock
//   rst_in           asynchronous active-low reset
//   rdy_in           global ready; low freezes every register
//   mem_req          fetch request, held until mem_done
//   mem_addr         fetch address, stable while mem_req is high
//   mem_done         one-cycle pulse, mem_data valid
//   mem_data         fetched instruction word
//   ins_valid        queue holds at least one entry
//   ins              head instruction word
//   ins_pc           PC of the head instruction
//   ins_pred_pc      predicted next PC of the head instruction
//   ins_pop          consumer takes the head this cycle
//   flush_in         redirect request
//   flush_pc_in      redirect target
// ----------------------------------------------------------------------------
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH_LOG = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic [31:0] ins_pred_pc,
  input  logic        ins_pop,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in
);

  fetch_state_e        state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                mem_req_q;
  logic [31:0]         mem_addr_q;

  logic [PC_WIDTH-1:0] next_pc_d;
  logic                issue_ok;
  logic                q_push;
  logic                q_pop;
  logic                q_clear;
  logic                q_full;
  logic                q_empty;

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ins_valid = !q_empty;

  // Where fetch goes after the word arriving on mem_data. Only consumed in
  // the cycle mem_done is accepted, so mem_data is always meaningful here.
  always_comb begin
    next_pc_d = pc_q + 32'd4;
`ifdef JAL_FOLLOW_EN
    if (mem_data[6:0] == OPC_JAL) begin
      next_pc_d = pc_q + jal_offset(mem_data);
    end
`endif
  end

  // Issue only if the response is guaranteed a slot: the queue must have
  // room once this cycle's pop has happened. A pop only takes effect on a
  // non-empty queue, and a full queue is never empty, so "not full or
  // popping" is exactly "occupancy after pop below depth".
  assign issue_ok = !q_full || ins_pop;

  // Queue strobes. Flush wins over everything: it empties the queue, the
  // pop is ignored, and a response landing in the flush cycle is dropped.
  assign q_clear = rdy_in && flush_in;
  assign q_pop   = rdy_in && !flush_in && ins_pop;
  assign q_push  = rdy_in && !flush_in && (state_q == FS_WAIT) && mem_done;

  // Fetch FSM with registered request outputs. mem_addr only changes when a
  // new request is issued, so it stays stable for the whole WAIT/DROP
  // period. A flush during an outstanding request moves to DROP so the
  // stale response is absorbed without being pushed; the flush target is
  // parked in pc_q and fetched once the old request has completed.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        pc_q <= flush_pc_in;
        case (state_q)
          FS_WAIT: begin
            if (mem_done) begin
              mem_req_q <= 1'b0;
              state_q   <= FS_IDLE;
            end else begin
              state_q <= FS_DROP;
            end
          end
          FS_DROP: begin
            if (mem_done) begin
              mem_req_q <= 1'b0;
              state_q   <= FS_IDLE;
            end
          end
          default: begin
            state_q <= FS_IDLE;
          end
        endcase
      end else begin
        case (state_q)
          FS_IDLE: begin
            if (issue_ok) begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= pc_q;
              state_q    <= FS_WAIT;
            end
          end
          FS_WAIT: begin
            if (mem_done) begin
              pc_q      <= next_pc_d;
              mem_req_q <= 1'b0;
              state_q   <= FS_IDLE;
            end
          end
          FS_DROP: begin
            if (mem_done) begin
              mem_req_q <= 1'b0;
              state_q   <= FS_IDLE;
            end
          end
          default: begin
            mem_req_q <= 1'b0;
            state_q   <= FS_IDLE;
          end
        endcase
      end
    end
  end

  ins_fetch_queue #(
    .DEPTH_LOG (QUEUE_DEPTH_LOG)
  ) u_queue (
    .clk_i          (clk_in),
    .rst_ni         (rst_in),
    .push_i         (q_push),
    .pop_i          (q_pop),
    .clear_i        (q_clear),
    .push_ins_i     (mem_data),
    .push_pc_i      (pc_q),
    .push_pred_pc_i (next_pc_d),
    .full_o         (q_full),
    .empty_o        (q_empty),
    .head_ins_o     (ins),
    .head_pc_o      (ins_pc),
    .head_pred_pc_o (ins_pred_pc)
  );

endmodule
